ram_sdp_param: RTL and testbench

Parametrised simple-dual-port RAM: one write port with byte enables, one independent read port, and a selectable output register. It adds two things the 16x1024 CPU RAM lacks: a write-first collision bypass and a hardware clear sequencer that zeroes memory after reset. It serves as the CPU data/instruction store and as a generic buffer for other blocks, and runs in a single clock domain.

---
 rtl/ram_pkg.sv | 27 ++
 rtl/ram_sdp_param_core.sv | 32 +++
 rtl/ram_sdp_param.sv | 143 ++++++++++++++
 tb/tb_ram_sdp_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM family.
// Holds the controller state encoding and the byte-enable merge used by the read bypass.
package ram_pkg;

    typedef enum logic {
        RAM_CLEAR,
        RAM_RUN
    } ram_state_e;

    // Widest word the merge helper handles; callers cast in and out of this width.
    localparam int MERGE_MAX_W  = 1024;
    localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

    function automatic logic [MERGE_MAX_W-1:0] merge_be(
        input logic [MERGE_MAX_W-1:0]  old_word,
        input logic [MERGE_MAX_W-1:0]  new_word,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MERGE_MAX_BE; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_sdp_param_core.sv
// Bare storage array: byte-enabled synchronous write, registered read, no reset.
// On a same-address collision the read returns the old word; the top level patches it.
module ram_sdp_param_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1 << ADDR_W,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BE_W-1:0]   wbe,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset at all; resetting it would stop the tools
    // mapping it onto block RAM. Non-blocking writes make a same-edge read see the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_sdp_param.sv
// Simple-dual-port RAM with byte enables, write-first collision bypass,
// post-reset clear sequencer and an optional output register.
module ram_sdp_param
    import ram_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 10,
    parameter int DEPTH          = 1 << ADDR_W,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter int BE_W           = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam logic [ADDR_W:0]   DEPTH_V     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam ram_state_e        RESET_STATE = (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_RUN;

    ram_state_e        state, state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clearing, running;
    logic              wr_in_range, rd_in_range, wr_accept, rd_accept;

    assign clearing    = (state == RAM_CLEAR);
    assign running     = (state == RAM_RUN);
    assign init_busy   = clearing;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_V);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_V);
    assign wr_accept   = running && wr_en && wr_in_range;
    assign rd_accept   = running && rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RESET_STATE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        if (clearing && (clr_cnt == LAST_ADDR)) state_next = RAM_RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           clr_cnt <= '0;
        else if (clearing) clr_cnt <= clr_cnt + 1'b1;
    end

    // The clear sequencer owns the write port until it finishes.
    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [BE_W-1:0]   core_wbe;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;

    assign core_we    = clearing || wr_accept;
    assign core_waddr = clearing ? clr_cnt : wr_addr;
    assign core_wbe   = clearing ? '1 : wr_be;
    assign core_wdata = clearing ? '0 : wr_data;

    ram_sdp_param_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BE_W   (BE_W)
    ) u_core (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wbe   (core_wbe),
        .wdata (core_wdata),
        .re    (rd_accept && rd_in_range),
        .raddr (rd_addr),
        .rdata (core_rdata)
    );

    // Read-side context captured with each accepted read; it only changes on a
    // new read, so the first-stage data holds between reads.
    logic              s1_valid, s1_zero, byp_hit;
    logic [BE_W-1:0]   byp_be;
    logic [DATA_W-1:0] byp_data;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b1;
            byp_hit  <= 1'b0;
            byp_be   <= '0;
            byp_data <= '0;
        end else begin
            s1_valid <= rd_accept;
            if (rd_accept) begin
                s1_zero  <= !rd_in_range;
                byp_hit  <= wr_accept && (wr_addr == rd_addr);
                byp_be   <= wr_be;
                byp_data <= wr_data;
            end
        end
    end

    always_comb begin
        s1_data = core_rdata;
        if (s1_zero) begin
            s1_data = '0;
        end else if (byp_hit) begin
            s1_data = DATA_W'(merge_be(MERGE_MAX_W'(core_rdata), MERGE_MAX_W'(byp_data),
                                       MERGE_MAX_BE'(byp_be)));
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] out_data;
        logic              out_valid;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_data  <= '0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= s1_valid;
                if (s1_valid) out_data <= s1_data;
            end
        end

        assign rd_data  = out_data;
        assign rd_valid = out_valid;
    end else begin : g_out_direct
        assign rd_data  = s1_data;
        assign rd_valid = s1_valid;
    end

endmodule

// File: tb/tb_ram_sdp_param.sv
// Scoreboard bench: three instances (1-cycle, 2-cycle, DEPTH=1000) share one stimulus
// stream; each read pushes its expected word and due cycle, a monitor pops on rd_valid.
module tb_ram_sdp_param;

    typedef struct packed {
        logic [15:0] data;
        logic [31:0] due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [9:0]  wr_addr, rd_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;

    logic        busy [3];
    logic        rdv  [3];
    logic [15:0] rdd  [3];

    exp_t exp_q [3][$];
    int   valid_cnt [3];
    int   run_len   [3];
    int   max_run   [3];
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    ram_sdp_param #(.OUT_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .init_busy(busy[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_valid(rdv[0])
    );

    ram_sdp_param #(.OUT_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .init_busy(busy[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_valid(rdv[1])
    );

    ram_sdp_param #(.DEPTH(1000), .OUT_REG(0)) u_dut2 (
        .clk(clk), .rst(rst), .init_busy(busy[2]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[2]), .rd_valid(rdv[2])
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares data and arrival cycle for every rd_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rdv[k] === 1'b1) begin
                valid_cnt[k]++;
                run_len[k]++;
                if (run_len[k] > max_run[k]) max_run[k] = run_len[k];
                if (exp_q[k].size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected rd_valid dut%0d: got data 0x%0h, expected no pulse", k, rdd[k]);
                end else begin
                    e = exp_q[k].pop_front();
                    check($sformatf("rd_data dut%0d", k), 32'(rdd[k]), 32'(e.data));
                    check($sformatf("rd latency dut%0d", k), 32'(cyc_cnt), e.due);
                end
            end else begin
                run_len[k] = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [9:0] addr, input logic [1:0] be, input logic [15:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_be = be; wr_data = data;
        step();
        wr_en = 1'b0; wr_be = 2'b00;
    endtask

    // Sets up a read for the next edge; exp_a for the 1024-word parts, exp_c for DEPTH=1000.
    task automatic push_read(input logic [9:0] addr, input logic [15:0] exp_a, input logic [15:0] exp_c);
        rd_en = 1'b1; rd_addr = addr;
        exp_q[0].push_back('{data: exp_a, due: 32'(cyc_cnt + 1)});
        exp_q[1].push_back('{data: exp_a, due: 32'(cyc_cnt + 2)});
        exp_q[2].push_back('{data: exp_c, due: 32'(cyc_cnt + 1)});
    endtask

    // Counts init_busy-high cycles per instance; issues an ignored read at cycle read_at.
    task automatic measure_clear(input int read_at);
        int n [3];
        int cyc;
        int exp_len [3];
        exp_len = '{1024, 1024, 1000};
        n = '{0, 0, 0};
        cyc = 0;
        while ((busy[0] || busy[1] || busy[2]) && cyc < 3000) begin
            for (int k = 0; k < 3; k++) if (busy[k]) n[k]++;
            rd_en = (cyc == read_at);
            rd_addr = 10'd0;
            step();
            cyc++;
        end
        rd_en = 1'b0;
        for (int k = 0; k < 3; k++) check($sformatf("clear length dut%0d", k), 32'(n[k]), 32'(exp_len[k]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
        for (int k = 0; k < 3; k++) begin
            valid_cnt[k] = 0; run_len[k] = 0; max_run[k] = 0;
        end
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset init_busy dut%0d", k), 32'(busy[k]), 32'd1);
            check($sformatf("reset rd_valid dut%0d", k), 32'(rdv[k]), 32'd0);
            check($sformatf("reset rd_data dut%0d", k), 32'(rdd[k]), 32'd0);
        end
        rst = 1'b0;
        measure_clear(100);

        // Read in flight when reset hits, then reset again at clear count 300.
        rd_en = 1'b1; rd_addr = 10'd0;
        @(posedge clk);
        #1 rst = 1'b1; rd_en = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            rd_en = (c == 50);
            step();
        end
        rd_en = 1'b0;
        for (int k = 0; k < 3; k++) check($sformatf("busy at count 300 dut%0d", k), 32'(busy[k]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        measure_clear(100);
        for (int k = 0; k < 3; k++) check($sformatf("no rd_valid in clear dut%0d", k), 32'(valid_cnt[k]), 32'd0);

        // Cleared contents; 1023 is out of range for the DEPTH=1000 part.
        push_read(10'd0, 16'h0000, 16'h0000);    step();
        push_read(10'd511, 16'h0000, 16'h0000);  step();
        push_read(10'd1023, 16'h0000, 16'h0000); step();
        rd_en = 1'b0;

        // Partial byte write over a full word.
        do_write(10'd5, 2'b11, 16'hBEEF);
        do_write(10'd5, 2'b01, 16'h1234);
        push_read(10'd5, 16'hBE34, 16'hBE34); step();
        rd_en = 1'b0;

        // Write-first collision with a high-byte-only write.
        do_write(10'd7, 2'b11, 16'h1111);
        wr_en = 1'b1; wr_addr = 10'd7; wr_be = 2'b10; wr_data = 16'hAAAA;
        push_read(10'd7, 16'hAA11, 16'hAA11);
        step();
        wr_en = 1'b0; wr_be = 2'b00; rd_en = 1'b0;

        // wr_be = 0 is a no-op.
        do_write(10'd7, 2'b00, 16'h5A5A);
        push_read(10'd7, 16'hAA11, 16'hAA11); step();
        rd_en = 1'b0;

        // Preload and back-to-back burst.
        for (int i = 0; i < 16; i++) do_write(10'(i), 2'b11, 16'(i));
        for (int k = 0; k < 3; k++) max_run[k] = 0;
        for (int i = 0; i < 16; i++) begin
            push_read(10'(i), 16'(i), 16'(i));
            step();
        end
        rd_en = 1'b0;
        repeat (4) step();
        for (int k = 0; k < 3; k++) check($sformatf("burst valid run dut%0d", k), 32'(max_run[k]), 32'd16);

        // Independent write and read to different addresses in one cycle.
        wr_en = 1'b1; wr_addr = 10'd20; wr_be = 2'b11; wr_data = 16'h5555;
        push_read(10'd3, 16'h0003, 16'h0003);
        step();
        wr_en = 1'b0; wr_be = 2'b00;
        push_read(10'd20, 16'h5555, 16'h5555); step();
        rd_en = 1'b0;

        // Address 1010: in range for 1024 words, dropped and read as 0 for DEPTH=1000.
        do_write(10'd1010, 2'b11, 16'hFFFF);
        push_read(10'd1010, 16'hFFFF, 16'h0000); step();
        push_read(10'd10, 16'h000A, 16'h000A);   step();
        rd_en = 1'b0;

        for (int c = 0; c < 50; c++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
            step();
        end
        repeat (5) step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("pending reads dut%0d", k), 32'(exp_q[k].size()), 32'd0);
            check($sformatf("rd_data hold dut%0d", k), 32'(rdd[k]), 32'h000A);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
